// File: rtl/exp_mul_core.sv
// exp_mul_core: shift-add multiply / modular exponent engine.
// A*B or A^B mod 2^WIDTH_P, with a sticky truncation flag.
module exp_mul_core #(
    parameter int WIDTH_IN = 4,
    parameter int WIDTH_P  = 30
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic                i_start,
    input  logic                i_select,
    input  logic [WIDTH_IN-1:0] i_A,
    input  logic [WIDTH_IN-1:0] i_B,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ovf,
    output logic [WIDTH_P-1:0]  o_P
);

    localparam int SW = $clog2(WIDTH_IN);
    localparam int WS = WIDTH_P + WIDTH_IN;
    localparam logic [SW-1:0]       LAST_S = SW'(WIDTH_IN - 1);
    localparam logic [SW-1:0]       ONE_S  = SW'(1);
    localparam logic [WIDTH_IN-1:0] ONE_I  = WIDTH_IN'(1);
    localparam logic [WIDTH_P-1:0]  ONE_P  = WIDTH_P'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t r_state, w_next;

    logic [WIDTH_IN-1:0] r_A, r_B, r_iter;
    logic                r_sel;
    logic [SW-1:0]       r_step;
    logic [WIDTH_P-1:0]  r_acc, r_P;
    logic [WS-1:0]       r_part;
    logic                r_busy, r_done, r_ovf;

    logic          w_load, w_start, w_last_step, w_last_iter;
    logic          w_zero_exp, w_finish;
    logic [WS-1:0] w_term, w_sum;

    assign w_load      = i_load && (r_state != RUN);
    assign w_start     = i_start && !i_load && (r_state != RUN);
    assign w_last_step = (r_step == LAST_S);
    assign w_last_iter = ((r_iter + ONE_I) == r_B);
    assign w_zero_exp  = r_sel && (r_B == '0);

    // Multiply accumulates A<<i in r_part; exponent accumulates acc<<i.
    always_comb begin
        w_term = '0;
        if (r_sel) begin
            if (r_A[r_step]) w_term = WS'(r_acc) << r_step;
        end else begin
            if (r_B[r_step]) w_term = WS'(r_A) << r_step;
        end
    end

    assign w_sum    = r_part + w_term;
    assign w_finish = (r_state == RUN) &&
                      (w_zero_exp || (w_last_step && (!r_sel || w_last_iter)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_load)        w_next = IDLE;
        else if (w_start)  w_next = RUN;
        else if (w_finish) w_next = DONE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_A    <= '0;
            r_B    <= '0;
            r_sel  <= 1'b0;
            r_iter <= '0;
            r_step <= '0;
            r_acc  <= '0;
            r_part <= '0;
            r_P    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_load) begin
            r_A    <= i_A;
            r_B    <= i_B;
            r_sel  <= i_select;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_start) begin
            r_P    <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_step <= '0;
            r_iter <= '0;
            r_part <= '0;
            r_acc  <= r_sel ? ONE_P : '0;
        end else if (r_state == RUN) begin
            if (w_zero_exp) begin
                r_P    <= r_acc;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_step <= r_step + ONE_S;
                r_part <= w_sum;
                if (w_last_step && r_sel) begin
                    r_acc  <= w_sum[WIDTH_P-1:0];
                    r_part <= '0;
                    r_iter <= r_iter + ONE_I;
                    r_ovf  <= r_ovf | (|w_sum[WS-1:WIDTH_P]);
                end
                if (w_finish) begin
                    r_P    <= w_sum[WIDTH_P-1:0];
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_ovf  = r_ovf;
    assign o_P    = r_P;

endmodule
